pipe_hazard_ctl: RTL and testbench
==================================

// Module: pipe_hazard_ctl
// PURPOSE
//  Producer side of the forwarding/stall interface. Carries each decoded instruction's hazard
//  fields (r1/r2 addr, waddr, rw, sel_mem) down stages 3-5 and feeds them to the forwarding unit.
//  Consumes that unit's stall_pipe: holds fetch/decode and injects bubbles into stage 3.
//  Also handles control-transfer flush, data-memory wait freeze and stall statistics.
// PARAMETERS
//  REG_WORDS  32  register file depth; ADDR_LEFT = $clog2(REG_WORDS)-1
//  CNT_BITS   16  width of stall_cnt performance counter
//  MAX_STALL  2   max legal consecutive stall_pipe cycles before stall_err
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst_           in   1           asynchronous active-low reset
//  r1_addr        in   ADDR_LEFT+1 decode-stage source 1
//  r2_addr        in   ADDR_LEFT+1 decode-stage source 2
//  waddr          in   ADDR_LEFT+1 decode-stage destination
//  rw             in   1           decode instr writes register
//  sel_mem        in   1           decode instr is a load
//  flush          in   1           taken branch/jr resolved in decode; kill fetched instr
//  stall_pipe     in   1           from forwarding unit
//  mem_wait       in   1           data memory not ready; freeze whole pipe
//  r1_addr_s3     out  ADDR_LEFT+1 stage-3 source 1
//  r2_addr_s3     out  ADDR_LEFT+1 stage-3 source 2
//  waddr_s3/s4/s5 out  ADDR_LEFT+1 destination per stage
//  rw_s3/s4/s5    out  1           write-enable per stage
//  sel_mem_s3/s4/s5 out 1          load flag per stage
//  pc_en          out  1           PC may advance
//  id_en          out  1           IF/ID register may load
//  id_kill        out  1           IF/ID register loads a bubble
//  stall_cnt      out  CNT_BITS    cycles with stall_pipe applied, saturating
//  stall_err      out  1           sticky: stall exceeded MAX_STALL
// BEHAVIOUR
//  Reset (rst_=0, async): all *_s3/s4/s5 fields 0, stall_cnt 0, stall_err 0, run-length 0.
//  Priority per cycle: mem_wait > stall_pipe > flush > normal.
//  normal: s3<=decode fields, s4<=s3, s5<=s4; pc_en=1, id_en=1, id_kill=0.
//  stall_pipe (mem_wait=0): s3<=bubble (rw=0, sel_mem=0, waddr=0, r1/r2=0); s4<=s3; s5<=s4;
//   pc_en=0, id_en=0; flush ignored this cycle (decoder re-asserts after stall clears).
//  flush (no stall, no wait): pipe advances as normal, decode instr enters s3; pc_en=1,
//   id_en=1, id_kill=1 (IF/ID loads bubble).
//  mem_wait=1: s3/s4/s5 hold, pc_en=0, id_en=0, id_kill=0; stall_pipe/flush ignored,
//   stall_cnt and run-length not updated.
//  pc_en/id_en/id_kill: combinational from inputs; 0-cycle latency. Stage fields: 1 cycle.
//  Bubble invariant: rw=0 in any stage implies waddr=0 in that stage.
//  stall_cnt: +1 on each applied stall cycle; holds at 2^CNT_BITS-1.
//  Run-length counter: +1 per applied stall cycle, 0 on any non-wait cycle without stall.
//   stall_err set when run-length would exceed MAX_STALL; clears only on reset.
//  Reset mid-stall: all fields cleared, pipe resumes as normal when rst_ rises.
// TESTING
//  1: decode waddr=5, rw=1, then 3 NOPs -> waddr_s3=5 at cycle+1, s4=5 at +2, s5=5 at +3.
//  2: load (sel_mem=1, waddr=7) in s3, stall_pipe=1 for 2 cycles -> pc_en=id_en=0 both
//     cycles; s3 rw=0, waddr=0; load reaches s5 at cycle+2; stall_cnt=2; stall_err=0.
//  3: stall_pipe=1 and flush=1 same cycle -> id_kill=0, bubble in s3; next cycle flush
//     alone -> id_kill=1, pc_en=1.
//  4: mem_wait=1 for 3 cycles with stall_pipe=1 -> s3..s5 unchanged, stall_cnt unchanged.
//  5: stall_pipe=1 for 3 consecutive cycles, MAX_STALL=2 -> stall_err=1 after 3rd edge
//     and stays 1 after stall_pipe drops.
//  6: CNT_BITS=4, 20 stall cycles -> stall_cnt=15; assert rst_=0 mid-stall -> all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// Hazard-field pipeline for stages 3-5 plus fetch/decode hold, bubble injection,
// flush kill, memory-wait freeze and stall statistics.
module pipe_hazard_ctl #(
  parameter int REG_WORDS = 32,
  parameter int CNT_BITS  = 16,
  parameter int MAX_STALL = 2,
  localparam int ADDR_LEFT = $clog2(REG_WORDS) - 1
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [ADDR_LEFT:0]  r1_addr,
  input  logic [ADDR_LEFT:0]  r2_addr,
  input  logic [ADDR_LEFT:0]  waddr,
  input  logic                rw,
  input  logic                sel_mem,
  input  logic                flush,
  input  logic                stall_pipe,
  input  logic                mem_wait,
  output logic [ADDR_LEFT:0]  r1_addr_s3,
  output logic [ADDR_LEFT:0]  r2_addr_s3,
  output logic [ADDR_LEFT:0]  waddr_s3,
  output logic [ADDR_LEFT:0]  waddr_s4,
  output logic [ADDR_LEFT:0]  waddr_s5,
  output logic                rw_s3,
  output logic                rw_s4,
  output logic                rw_s5,
  output logic                sel_mem_s3,
  output logic                sel_mem_s4,
  output logic                sel_mem_s5,
  output logic                pc_en,
  output logic                id_en,
  output logic                id_kill,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic                stall_err
);

  // Run length saturates one above the limit so it never wraps back into the legal range.
  localparam int RUNW = $clog2(MAX_STALL + 2);
  localparam logic [RUNW-1:0] RUN_LIM = RUNW'(MAX_STALL);
  localparam logic [RUNW-1:0] RUN_MAX = RUNW'(MAX_STALL + 1);

  typedef struct packed {
    logic [ADDR_LEFT:0] waddr;
    logic               rw;
    logic               sel_mem;
  } dst_t;

  dst_t               s3_q, s3_d, s4_q, s4_d, s5_q, s5_d;
  logic [ADDR_LEFT:0] r1_s3_q, r1_s3_d, r2_s3_q, r2_s3_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [RUNW-1:0]    run_q, run_d;
  logic               err_q, err_d;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == '1) ? v : v + CNT_BITS'(1);
  endfunction

  function automatic logic [RUNW-1:0] run_inc(input logic [RUNW-1:0] v);
    return (v == RUN_MAX) ? v : v + RUNW'(1);
  endfunction

  // A non-writing instruction carries waddr=0 so downstream compares never see a stale target.
  function automatic dst_t mk_dst(input logic [ADDR_LEFT:0] wa, input logic wr, input logic ld);
    dst_t d;
    d.waddr   = wr ? wa : '0;
    d.rw      = wr;
    d.sel_mem = ld;
    return d;
  endfunction

  assign pc_en   = ~mem_wait & ~stall_pipe;
  assign id_en   = ~mem_wait & ~stall_pipe;
  assign id_kill = ~mem_wait & ~stall_pipe & flush;

  always_comb begin
    s3_d    = s3_q;
    s4_d    = s4_q;
    s5_d    = s5_q;
    r1_s3_d = r1_s3_q;
    r2_s3_d = r2_s3_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    err_d   = err_q;
    if (!mem_wait) begin
      s4_d = s3_q;
      s5_d = s4_q;
      if (stall_pipe) begin
        s3_d    = '0;
        r1_s3_d = '0;
        r2_s3_d = '0;
        cnt_d   = sat_inc(cnt_q);
        run_d   = run_inc(run_q);
        if (run_q >= RUN_LIM) err_d = 1'b1;
      end else begin
        s3_d    = mk_dst(waddr, rw, sel_mem);
        r1_s3_d = r1_addr;
        r2_s3_d = r2_addr;
        run_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s3_q    <= '0;
      s4_q    <= '0;
      s5_q    <= '0;
      r1_s3_q <= '0;
      r2_s3_q <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      s3_q    <= s3_d;
      s4_q    <= s4_d;
      s5_q    <= s5_d;
      r1_s3_q <= r1_s3_d;
      r2_s3_q <= r2_s3_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign r1_addr_s3 = r1_s3_q;
  assign r2_addr_s3 = r2_s3_q;
  assign waddr_s3   = s3_q.waddr;
  assign waddr_s4   = s4_q.waddr;
  assign waddr_s5   = s5_q.waddr;
  assign rw_s3      = s3_q.rw;
  assign rw_s4      = s4_q.rw;
  assign rw_s5      = s5_q.rw;
  assign sel_mem_s3 = s3_q.sel_mem;
  assign sel_mem_s4 = s4_q.sel_mem;
  assign sel_mem_s5 = s5_q.sel_mem;
  assign stall_cnt  = cnt_q;
  assign stall_err  = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: directed table, counter saturation / mid-stall reset,
// then random traffic against a queue-style reference model. Two instances share inputs.
module tb_pipe_hazard_ctl;
  localparam int AW = 5;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  logic rst_;
  logic [AW-1:0] r1_addr, r2_addr, waddr;
  logic rw, sel_mem, flush, stall_pipe, mem_wait;

  logic [AW-1:0] a_r1, a_r2, a_w3, a_w4, a_w5, b_r1, b_r2, b_w3, b_w4, b_w5;
  logic a_rw3, a_rw4, a_rw5, a_sm3, a_sm4, a_sm5, a_pc, a_id, a_kl, a_err;
  logic b_rw3, b_rw4, b_rw5, b_sm3, b_sm4, b_sm5, b_pc, b_id, b_kl, b_err;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  pipe_hazard_ctl #(.REG_WORDS(32), .CNT_BITS(16), .MAX_STALL(MAXS)) u_a (
    .clk(clk), .rst_(rst_), .r1_addr(r1_addr), .r2_addr(r2_addr), .waddr(waddr),
    .rw(rw), .sel_mem(sel_mem), .flush(flush), .stall_pipe(stall_pipe), .mem_wait(mem_wait),
    .r1_addr_s3(a_r1), .r2_addr_s3(a_r2), .waddr_s3(a_w3), .waddr_s4(a_w4), .waddr_s5(a_w5),
    .rw_s3(a_rw3), .rw_s4(a_rw4), .rw_s5(a_rw5),
    .sel_mem_s3(a_sm3), .sel_mem_s4(a_sm4), .sel_mem_s5(a_sm5),
    .pc_en(a_pc), .id_en(a_id), .id_kill(a_kl), .stall_cnt(a_cnt), .stall_err(a_err));

  pipe_hazard_ctl #(.REG_WORDS(32), .CNT_BITS(4), .MAX_STALL(MAXS)) u_b (
    .clk(clk), .rst_(rst_), .r1_addr(r1_addr), .r2_addr(r2_addr), .waddr(waddr),
    .rw(rw), .sel_mem(sel_mem), .flush(flush), .stall_pipe(stall_pipe), .mem_wait(mem_wait),
    .r1_addr_s3(b_r1), .r2_addr_s3(b_r2), .waddr_s3(b_w3), .waddr_s4(b_w4), .waddr_s5(b_w5),
    .rw_s3(b_rw3), .rw_s4(b_rw4), .rw_s5(b_rw5),
    .sel_mem_s3(b_sm3), .sel_mem_s4(b_sm4), .sel_mem_s5(b_sm5),
    .pc_en(b_pc), .id_en(b_id), .id_kill(b_kl), .stall_cnt(b_cnt), .stall_err(b_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] r1, r2, wa;
    bit rw, sm, fl, st, mw;
    bit e_pc, e_id, e_kl;
    int e_w3, e_w4, e_w5, e_cnt;
    bit e_err;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] r1, r2, wa;
    logic rw, sm;
  } ent_t;

  // Reference state: instruction slots for stages 3,4,5 and plain integer statistics.
  ent_t pipe [3];
  int   m_stalls, m_run;
  bit   m_err;
  vec_t cur;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t row(int r1, int wa, bit rwv, bit sm, bit fl, bit st, bit mw,
                               bit pc, bit id, bit kl, int w3, int w4, int w5, int cnt, bit err);
    vec_t v;
    v.r1 = AW'(r1); v.r2 = AW'(r1 + 1); v.wa = AW'(wa);
    v.rw = rwv; v.sm = sm; v.fl = fl; v.st = st; v.mw = mw;
    v.e_pc = pc; v.e_id = id; v.e_kl = kl;
    v.e_w3 = w3; v.e_w4 = w4; v.e_w5 = w5; v.e_cnt = cnt; v.e_err = err;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_stalls = 0; m_run = 0; m_err = 0;
  endtask

  task automatic model_step(input vec_t v);
    ent_t e;
    if (v.mw) return;
    if (v.st) begin
      m_stalls++;
      m_run++;
      if (m_run > MAXS) m_err = 1;
      e = '0;
    end else begin
      m_run = 0;
      e.r1 = v.r1; e.r2 = v.r2; e.wa = v.rw ? v.wa : '0; e.rw = v.rw; e.sm = v.sm;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
  endtask

  task automatic check_model(input string tag);
    logic [2:0] ctl;
    int ca, cb;
    ctl[2] = !cur.mw && !cur.st;
    ctl[1] = !cur.mw && !cur.st;
    ctl[0] = !cur.mw && !cur.st && cur.fl;
    ca = (m_stalls > 65535) ? 65535 : m_stalls;
    cb = (m_stalls > 15) ? 15 : m_stalls;
    chk({tag, ".a_s3"}, {a_r1, a_r2, a_w3, a_rw3, a_sm3}, pipe[0]);
    chk({tag, ".a_s4"}, {a_w4, a_rw4, a_sm4}, {pipe[1].wa, pipe[1].rw, pipe[1].sm});
    chk({tag, ".a_s5"}, {a_w5, a_rw5, a_sm5}, {pipe[2].wa, pipe[2].rw, pipe[2].sm});
    chk({tag, ".a_ctl"}, {a_pc, a_id, a_kl}, ctl);
    chk({tag, ".a_cnt"}, a_cnt, ca);
    chk({tag, ".a_err"}, a_err, m_err);
    chk({tag, ".b_s3"}, {b_r1, b_r2, b_w3, b_rw3, b_sm3}, pipe[0]);
    chk({tag, ".b_s45"}, {b_w4, b_rw4, b_sm4, b_w5, b_rw5, b_sm5},
        {pipe[1].wa, pipe[1].rw, pipe[1].sm, pipe[2].wa, pipe[2].rw, pipe[2].sm});
    chk({tag, ".b_ctl"}, {b_pc, b_id, b_kl}, ctl);
    chk({tag, ".b_cnt"}, b_cnt, cb);
    chk({tag, ".b_err"}, b_err, m_err);
  endtask

  task automatic drive(input vec_t v);
    cur = v;
    r1_addr = v.r1; r2_addr = v.r2; waddr = v.wa; rw = v.rw; sel_mem = v.sm;
    flush = v.fl; stall_pipe = v.st; mem_wait = v.mw;
  endtask

  task automatic advance(input vec_t v);
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check_model(tag);
    advance(v);
  endtask

  vec_t tbl [20];
  vec_t v;

  initial begin
    // Directed sequence: expected outputs are those seen mid-cycle, before that row's edge.
    //            r1 wa rw sm fl st mw  pc id kl  w3 w4 w5 cnt err
    tbl[0]  = row(0, 5, 1, 0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0, 0);
    tbl[1]  = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  5, 0, 0, 0, 0);
    tbl[2]  = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 5, 0, 0, 0);
    tbl[3]  = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 5, 0, 0);
    tbl[4]  = row(1, 7, 1, 1, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0, 0);
    tbl[5]  = row(7, 2, 1, 0, 0, 1, 0,  0, 0, 0,  7, 0, 0, 0, 0);
    tbl[6]  = row(7, 2, 1, 0, 0, 1, 0,  0, 0, 0,  0, 7, 0, 1, 0);
    tbl[7]  = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 7, 2, 0);
    tbl[8]  = row(4, 9, 1, 0, 1, 1, 0,  0, 0, 0,  0, 0, 0, 2, 0);
    tbl[9]  = row(4, 3, 1, 0, 1, 0, 0,  1, 1, 1,  0, 0, 0, 3, 0);
    tbl[10] = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  3, 0, 0, 3, 0);
    tbl[11] = row(2, 6, 1, 0, 0, 1, 1,  0, 0, 0,  0, 3, 0, 3, 0);
    tbl[12] = row(2, 6, 1, 0, 0, 1, 1,  0, 0, 0,  0, 3, 0, 3, 0);
    tbl[13] = row(2, 6, 1, 0, 1, 1, 1,  0, 0, 0,  0, 3, 0, 3, 0);
    tbl[14] = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 3, 0, 3, 0);
    tbl[15] = row(0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 3, 3, 0);
    tbl[16] = row(0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 4, 0);
    tbl[17] = row(0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 5, 0);
    tbl[18] = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 6, 1);
    tbl[19] = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 6, 1);

    rst_ = 1'b0;
    drive(row(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    model_reset();
    #3;
    check_model("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_ = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d.ctl", i), {a_pc, a_id, a_kl}, {tbl[i].e_pc, tbl[i].e_id, tbl[i].e_kl});
      chk($sformatf("tbl%0d.wa", i), {a_w3, a_w4, a_w5},
          {AW'(tbl[i].e_w3), AW'(tbl[i].e_w4), AW'(tbl[i].e_w5)});
      chk($sformatf("tbl%0d.cnt", i), a_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d.err", i), a_err, tbl[i].e_err);
      check_model($sformatf("tbl%0d", i));
      advance(tbl[i]);
    end

    // Long stall run: the 4-bit counter must pin at 15 while the 16-bit one keeps counting.
    v = row(3, 8, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) apply(v, "long_stall");
    chk("sat.b_cnt", b_cnt, 15);
    chk("sat.a_cnt", a_cnt, 26);
    chk("sat.err_sticky", {a_err, b_err}, 2'b11);

    // Asynchronous reset in the middle of the stall, away from any clock edge.
    drive(v);
    #2 rst_ = 1'b0;
    model_reset();
    #1;
    check_model("midrst");
    chk("midrst.all", {a_r1, a_r2, a_w3, a_w4, a_w5, a_rw3, a_rw4, a_rw5, a_sm3, a_sm4, a_sm5,
                       a_pc, a_id, a_kl, a_cnt, a_err, b_cnt, b_err}, '0);
    @(posedge clk);
    #1 rst_ = 1'b1;
    v = row(1, 4, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    apply(v, "resume");
    apply(row(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "resume2");

    for (int i = 0; i < 400; i++) begin
      v.r1 = AW'($urandom);
      v.r2 = AW'($urandom);
      v.wa = AW'($urandom);
      v.rw = ($urandom_range(0, 3) != 0);
      v.sm = ($urandom_range(0, 3) == 0);
      v.fl = ($urandom_range(0, 4) == 0);
      v.st = ($urandom_range(0, 3) == 0);
      v.mw = ($urandom_range(0, 6) == 0);
      apply(v, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
